// File: rtl/fifo_sync_fwft_pkg.sv
// Shared types and elaboration helpers for the synchronous FIFO family.
package fifo_sync_fwft_pkg;

  // Read-side behaviour of the FIFO.
  typedef enum logic {
    FIFO_STD  = 1'b0,  // rdata valid one cycle after an accepted ren
    FIFO_FWFT = 1'b1   // head word presented without a request
  } fifo_mode_t;

  // Width needed to count 0..2**addr_w inclusive.
  function automatic int load_width(input int addr_w);
    return $clog2((1 << addr_w) + 1);
  endfunction

  // Maps the integer FWFT parameter onto the mode enum.
  function automatic fifo_mode_t mode_from_param(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/fifo_sync_fwft_if.sv
// Streaming/status bundle between the FIFO and its producer/consumer.
// ADDR_W and DATA_W must match the parameters of the FIFO it connects to.
interface fifo_sync_fwft_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();

  localparam int LOAD_W = fifo_sync_fwft_pkg::load_width(ADDR_W);

  logic              flush;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              full;
  logic              afull;
  logic [DATA_W-1:0] rdata;
  logic              ren;
  logic              rvalid;
  logic              empty;
  logic              aempty;
  logic [LOAD_W-1:0] load;
  logic              ovf;
  logic              udf;

  // User side: pushes, pops and flushes; observes status.
  modport master (
    output flush, wdata, wen, ren,
    input  full, afull, rdata, rvalid, empty, aempty, load, ovf, udf
  );

  // FIFO side.
  modport slave (
    input  flush, wdata, wen, ren,
    output full, afull, rdata, rvalid, empty, aempty, load, ovf, udf
  );

endinterface

// File: rtl/fifo_sync_fwft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// rdata holds its last value whenever rd is low.
module fifo_sync_fwft_dpram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port.
  // NOTE: the storage array has no reset on purpose -- a reset would stop it mapping onto block RAM,
  // and the FIFO never reads a location it has not written since the last rst/flush.
  always_ff @(posedge clk) begin
    if (we) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds when idle.
  always_ff @(posedge clk) begin
    if (rd) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read side,
// programmable almost-full/almost-empty levels, synchronous flush and sticky
// overflow/underflow flags. Buffers data between the proto245 engine and user streams.
module fifo_sync_fwft
  import fifo_sync_fwft_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int WORDS_TOTAL = 2**ADDR_W,
  parameter int FWFT        = 1,
  parameter int AFULL_LVL   = WORDS_TOTAL - 1,
  parameter int AEMPTY_LVL  = 1
) (
  input logic             clk,
  input logic             rst,
  fifo_sync_fwft_if.slave bus
);

  localparam int                LOAD_W    = load_width(ADDR_W);
  localparam fifo_mode_t        MODE      = mode_from_param(FWFT);
  localparam logic [LOAD_W-1:0] FULL_LD   = LOAD_W'(WORDS_TOTAL);
  localparam logic [LOAD_W-1:0] AFULL_LD  = LOAD_W'(AFULL_LVL);
  localparam logic [LOAD_W-1:0] AEMPTY_LD = LOAD_W'(AEMPTY_LVL);
  localparam logic [LOAD_W-1:0] LOAD_ONE  = LOAD_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [LOAD_W-1:0] load;
  logic              rvalid;
  logic              ovf;
  logic              udf;

  logic              full;
  logic              empty;
  logic              wr;          // accepted write this cycle
  logic              ram_rd;      // RAM read issued this cycle
  logic              dec;         // a word leaves the FIFO this cycle
  logic              rvalid_nxt;
  logic [DATA_W-1:0] ram_rdata;

  // Full is taken from registered load only, so a pop in the same cycle never frees a slot early.
  always_comb begin
    full = (load == FULL_LD);
    wr   = bus.wen & ~full;
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      logic [LOAD_W-1:0] ram_cnt;  // words in RAM, excluding the one on rdata
      logic              pop;

      // Prefetch control: refill the output register whenever it is empty or being popped.
      // NOTE: every always_comb output gets a value on every path (here unconditionally) so no latch is inferred.
      always_comb begin
        pop        = bus.ren & rvalid;
        ram_rd     = (ram_cnt != '0) & (~rvalid | pop);
        dec        = pop;
        rvalid_nxt = ram_rd | (rvalid & ~pop);
        empty      = ~rvalid;
      end

      // RAM occupancy counter: +1 per accepted write, -1 per prefetch.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ram_cnt <= '0;
        end else if (bus.flush) begin
          ram_cnt <= '0;
        end else begin
          case ({wr, ram_rd})
            2'b10:   ram_cnt <= ram_cnt + LOAD_ONE;
            2'b01:   ram_cnt <= ram_cnt - LOAD_ONE;
            default: ram_cnt <= ram_cnt;
          endcase
        end
      end

      // The presented word plus the RAM contents always account for the whole load.
      a_load_split: assert property (@(posedge clk) disable iff (rst)
        load == ram_cnt + LOAD_W'(rvalid));
    end else begin : g_std
      // Standard read side: a read is accepted whenever a word is held.
      always_comb begin
        empty      = (load == '0);
        ram_rd     = bus.ren & ~empty;
        dec        = ram_rd;
        rvalid_nxt = ram_rd;
      end
    end
  endgenerate

  // Pointers, occupancy, output-valid and sticky error flags; flush outranks wen/ren.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr  <= '0;
      raddr  <= '0;
      load   <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.flush) begin
      waddr  <= '0;
      raddr  <= '0;
      load   <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr) begin
        waddr <= waddr + ADDR_ONE;
      end
      if (ram_rd) begin
        raddr <= raddr + ADDR_ONE;
      end
      case ({wr, dec})
        2'b10:   load <= load + LOAD_ONE;
        2'b01:   load <= load - LOAD_ONE;
        default: load <= load;
      endcase
      rvalid <= rvalid_nxt;
      if (bus.wen & full) begin
        ovf <= 1'b1;
      end
      if (bus.ren & empty) begin
        udf <= 1'b1;
      end
    end
  end

  a_load_bound: assert property (@(posedge clk) disable iff (rst) load <= FULL_LD);

  fifo_sync_fwft_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr & ~bus.flush),
    .waddr (waddr),
    .wdata (bus.wdata),
    .rd    (ram_rd & ~bus.flush),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Status outputs; the threshold flags decode the registered load.
  always_comb begin
    bus.full   = full;
    bus.afull  = (load >= AFULL_LD);
    bus.empty  = empty;
    bus.aempty = (load <= AEMPTY_LD);
    bus.load   = load;
    bus.rvalid = rvalid;
    bus.rdata  = ram_rdata;
    bus.ovf    = ovf;
    bus.udf    = udf;
  end

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft: a 6-word standard-mode FIFO (ADDR_W=3, AFULL=5, AEMPTY=1)
// and an 8-word FWFT FIFO (ADDR_W=3, default levels) share clock and reset.
module tb_fifo_sync_fwft;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  // {full, afull, empty, aempty} for the 6-word standard instance at each load.
  localparam logic [3:0] F0 = 4'b0011;  // load 0
  localparam logic [3:0] F1 = 4'b0001;  // load 1
  localparam logic [3:0] FM = 4'b0000;  // load 2..4
  localparam logic [3:0] FA = 4'b0100;  // load 5
  localparam logic [3:0] FF = 4'b1100;  // load 6

  typedef struct {
    logic       wen;
    logic       ren;
    logic       flush;
    logic [7:0] wd;
    logic       rv;    // expected rvalid after the edge
    logic [7:0] rd;    // expected rdata when rv
    logic [3:0] ld;
    logic [3:0] flg;
    logic       ovf;
    logic       udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  fifo_sync_fwft_if #(.ADDR_W(3), .DATA_W(8)) bus_s ();
  fifo_sync_fwft_if #(.ADDR_W(3), .DATA_W(8)) bus_f ();

  fifo_sync_fwft #(
    .ADDR_W(3), .DATA_W(8), .WORDS_TOTAL(6), .FWFT(0), .AFULL_LVL(5), .AEMPTY_LVL(1)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  fifo_sync_fwft #(
    .ADDR_W(3), .DATA_W(8), .FWFT(1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic wen, input logic ren, input logic flush, input logic [7:0] wd);
    bus_s.wen = wen; bus_s.ren = ren; bus_s.flush = flush; bus_s.wdata = wd;
  endtask

  task automatic drive_f(input logic wen, input logic ren, input logic flush, input logic [7:0] wd);
    bus_f.wen = wen; bus_f.ren = ren; bus_f.flush = flush; bus_f.wdata = wd;
  endtask

  function automatic vec_t mk(input logic wen, input logic ren, input logic flush, input logic [7:0] wd,
                              input logic rv, input logic [7:0] rd, input logic [3:0] ld,
                              input logic [3:0] flg, input logic ovf, input logic udf);
    vec_t v;
    v.wen = wen; v.ren = ren; v.flush = flush; v.wd = wd;
    v.rv = rv; v.rd = rd; v.ld = ld; v.flg = flg; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  function automatic logic [3:0] flags_s();
    return {bus_s.full, bus_s.afull, bus_s.empty, bus_s.aempty};
  endfunction

  function automatic logic [3:0] flags_f();
    return {bus_f.full, bus_f.afull, bus_f.empty, bus_f.aempty};
  endfunction

  // Overflow at 7 writes into 6 words, thresholds at load 0..6, full with wen&ren,
  // empty with wen&ren, flush clearing the sticky flags.
  task automatic run_table();
    vq.push_back(mk(Y, N, N, 8'h01, N, 8'h00, 4'd1, F1, N, N));
    vq.push_back(mk(Y, N, N, 8'h02, N, 8'h00, 4'd2, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h03, N, 8'h00, 4'd3, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h04, N, 8'h00, 4'd4, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h05, N, 8'h00, 4'd5, FA, N, N));
    vq.push_back(mk(Y, N, N, 8'h06, N, 8'h00, 4'd6, FF, N, N));
    vq.push_back(mk(Y, N, N, 8'h07, N, 8'h00, 4'd6, FF, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h01, 4'd5, FA, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h02, 4'd4, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h03, 4'd3, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h04, 4'd2, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h05, 4'd1, F1, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h06, 4'd0, F0, Y, N));
    vq.push_back(mk(N, N, N, 8'h00, N, 8'h00, 4'd0, F0, Y, N));
    vq.push_back(mk(N, N, Y, 8'h00, N, 8'h00, 4'd0, F0, N, N));
    vq.push_back(mk(Y, N, N, 8'h10, N, 8'h00, 4'd1, F1, N, N));
    vq.push_back(mk(Y, N, N, 8'h11, N, 8'h00, 4'd2, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h12, N, 8'h00, 4'd3, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h13, N, 8'h00, 4'd4, FM, N, N));
    vq.push_back(mk(Y, N, N, 8'h14, N, 8'h00, 4'd5, FA, N, N));
    vq.push_back(mk(Y, N, N, 8'h15, N, 8'h00, 4'd6, FF, N, N));
    vq.push_back(mk(Y, Y, N, 8'h16, Y, 8'h10, 4'd5, FA, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h11, 4'd4, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h12, 4'd3, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h13, 4'd2, FM, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h14, 4'd1, F1, Y, N));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h15, 4'd0, F0, Y, N));
    vq.push_back(mk(Y, Y, N, 8'h77, N, 8'h00, 4'd1, F1, Y, Y));
    vq.push_back(mk(N, Y, N, 8'h00, Y, 8'h77, 4'd0, F0, Y, Y));
    vq.push_back(mk(N, N, Y, 8'h00, N, 8'h00, 4'd0, F0, N, N));

    foreach (vq[i]) begin
      drive_s(vq[i].wen, vq[i].ren, vq[i].flush, vq[i].wd);
      step();
      check("vec_rvalid", i, 32'(bus_s.rvalid), 32'(vq[i].rv));
      if (vq[i].rv) check("vec_rdata", i, 32'(bus_s.rdata), 32'(vq[i].rd));
      check("vec_load", i, 32'(bus_s.load), 32'(vq[i].ld));
      check("vec_flags", i, 32'(flags_s()), 32'(vq[i].flg));
      check("vec_ovf", i, 32'(bus_s.ovf), 32'(vq[i].ovf));
      check("vec_udf", i, 32'(bus_s.udf), 32'(vq[i].udf));
    end
    drive_s(N, N, N, 8'h00);
  endtask

  // Standard mode: three writes, three back-to-back reads, one rvalid pulse per word.
  task automatic run_std_burst();
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive_s(Y, N, N, d[i]);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive_s(N, Y, N, 8'h00);
      step();
      check("burst_rvalid", i, 32'(bus_s.rvalid), 32'(1));
      check("burst_rdata", i, 32'(bus_s.rdata), 32'(d[i]));
    end
    drive_s(N, N, N, 8'h00);
    step();
    check("burst_rvalid_end", 0, 32'(bus_s.rvalid), 32'(0));
    check("burst_empty", 0, 32'(bus_s.empty), 32'(1));
    check("burst_load", 0, 32'(bus_s.load), 32'(0));
    check("burst_udf", 0, 32'(bus_s.udf), 32'(0));
  endtask

  // FWFT: word written at cycle N is presented at N+2 and held without ren.
  task automatic run_fwft_latency();
    drive_f(Y, N, N, 8'hA5);
    step();
    drive_f(N, N, N, 8'h00);
    check("fwft_n1_rvalid", 0, 32'(bus_f.rvalid), 32'(0));
    check("fwft_n1_load", 0, 32'(bus_f.load), 32'(1));
    step();
    check("fwft_n2_rvalid", 0, 32'(bus_f.rvalid), 32'(1));
    check("fwft_n2_rdata", 0, 32'(bus_f.rdata), 32'h0000_00A5);
    check("fwft_n2_load", 0, 32'(bus_f.load), 32'(1));
    check("fwft_n2_empty", 0, 32'(bus_f.empty), 32'(0));
    repeat (2) step();
    check("fwft_hold_rvalid", 0, 32'(bus_f.rvalid), 32'(1));
    check("fwft_hold_rdata", 0, 32'(bus_f.rdata), 32'h0000_00A5);
    drive_f(N, Y, N, 8'h00);
    step();
    drive_f(N, N, N, 8'h00);
    check("fwft_pop_rvalid", 0, 32'(bus_f.rvalid), 32'(0));
    check("fwft_pop_empty", 0, 32'(bus_f.empty), 32'(1));
    check("fwft_pop_load", 0, 32'(bus_f.load), 32'(0));
  endtask

  // Standard mode streaming of 24 words through a 6-word FIFO with an 8-entry RAM.
  task automatic run_std_stream();
    logic [7:0] q[$];
    logic [7:0] wd;
    logic [7:0] exp;
    logic       do_w;
    logic       do_r;
    int         model;
    model = 0;
    exp   = 8'h00;
    for (int c = 0; c < 26; c++) begin
      do_w = (c < 24);
      do_r = (model > 0);
      wd   = 8'(c * 5 + 1);
      if (do_w) q.push_back(wd);
      if (do_r) exp = q.pop_front();
      drive_s(do_w, do_r, N, wd);
      model = model + int'(do_w) - int'(do_r);
      step();
      check("std_stream_rvalid", c, 32'(bus_s.rvalid), 32'(do_r));
      if (do_r) check("std_stream_rdata", c, 32'(bus_s.rdata), 32'(exp));
    end
    drive_s(N, N, N, 8'h00);
    check("std_stream_load", 0, 32'(bus_s.load), 32'(0));
    check("std_stream_flags", 0, 32'({bus_s.ovf, bus_s.udf, bus_s.empty}), 32'(3'b001));
  endtask

  // FWFT streaming: one word per cycle once the pipeline has filled.
  task automatic run_fwft_stream();
    logic [7:0] q[$];
    logic [7:0] wd;
    logic       do_w;
    logic       do_r;
    int         cyc;
    int         rx;
    int         wi;
    cyc = 0; rx = 0; wi = 0;
    while (rx < 24 && cyc < 60) begin
      do_w = (wi < 24);
      wd   = 8'(8'hC3 ^ (wi * 3));
      if (do_w) begin
        q.push_back(wd);
        wi++;
      end
      do_r = bus_f.rvalid;
      if (do_r) begin
        if (q.size() == 0) begin
          check("fwft_stream_spurious", rx, 32'(1), 32'(0));
        end else begin
          check("fwft_stream_data", rx, 32'(bus_f.rdata), 32'(q.pop_front()));
        end
        rx++;
      end
      drive_f(do_w, do_r, N, wd);
      step();
      cyc++;
    end
    drive_f(N, N, N, 8'h00);
    check("fwft_stream_count", 0, 32'(rx), 32'(24));
    check("fwft_stream_cycles", 0, 32'(cyc), 32'(26));
    check("fwft_stream_load", 0, 32'(bus_f.load), 32'(0));
    check("fwft_stream_flags", 0, 32'({bus_f.ovf, bus_f.udf, bus_f.empty}), 32'(3'b001));
  endtask

  // Flush with a simultaneous write, then an asynchronous reset between clock edges.
  task automatic run_flush_reset();
    drive_f(N, Y, N, 8'h00);
    step();
    check("pre_flush_udf", 0, 32'(bus_f.udf), 32'(1));
    for (int i = 0; i < 4; i++) begin
      drive_f(Y, N, N, 8'(8'h40 + i));
      step();
    end
    drive_f(N, N, N, 8'h00);
    repeat (2) step();
    check("pre_flush_load", 0, 32'(bus_f.load), 32'(4));
    check("pre_flush_rvalid", 0, 32'(bus_f.rvalid), 32'(1));
    drive_f(Y, N, Y, 8'hEE);
    step();
    drive_f(N, N, N, 8'h00);
    check("flush_load", 0, 32'(bus_f.load), 32'(0));
    check("flush_flags", 0, 32'(flags_f()), 32'(4'b0011));
    check("flush_rvalid", 0, 32'(bus_f.rvalid), 32'(0));
    check("flush_sticky", 0, 32'({bus_f.ovf, bus_f.udf}), 32'(2'b00));
    repeat (2) step();
    check("flush_dropped_load", 0, 32'(bus_f.load), 32'(0));
    check("flush_dropped_rvalid", 0, 32'(bus_f.rvalid), 32'(0));

    for (int i = 0; i < 3; i++) begin
      drive_f(Y, N, N, 8'(8'h90 + i));
      step();
    end
    drive_f(N, N, N, 8'h00);
    step();
    check("pre_rst_load", 0, 32'(bus_f.load), 32'(3));
    check("pre_rst_rvalid", 0, 32'(bus_f.rvalid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_load", 0, 32'(bus_f.load), 32'(0));
    check("async_rst_rvalid", 0, 32'(bus_f.rvalid), 32'(0));
    check("async_rst_flags", 0, 32'(flags_f()), 32'(4'b0011));
    #1;
    rst = 1'b0;
    step();
    check("post_rst_load", 0, 32'(bus_f.load), 32'(0));
    check("post_rst_rvalid", 0, 32'(bus_f.rvalid), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    drive_s(N, N, N, 8'h00);
    drive_f(N, N, N, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_std_flags", 0, 32'(flags_s()), 32'(4'b0011));
    check("rst_std_load", 0, 32'(bus_s.load), 32'(0));
    check("rst_std_misc", 0, 32'({bus_s.rvalid, bus_s.ovf, bus_s.udf}), 32'(3'b000));
    check("rst_fwft_flags", 0, 32'(flags_f()), 32'(4'b0011));
    check("rst_fwft_load", 0, 32'(bus_f.load), 32'(0));
    check("rst_fwft_misc", 0, 32'({bus_f.rvalid, bus_f.ovf, bus_f.udf}), 32'(3'b000));
    rst = 1'b0;
    step();

    run_table();
    run_std_burst();
    run_fwft_latency();
    run_std_stream();
    run_fwft_stream();
    run_flush_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
